mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Main control unit of the MIPS multicycle processor.
- Sequences the shared datapath (PC, IR, register file, ALU, and the 8:1 select muxes on ALU operand B and PC source) through fetch, decode, execute, memory and writeback.
- Moore FSM: outputs decode from the state register only. Memory accesses use a req/ready handshake.
- Sits between the instruction register opcode field and all datapath enables and selects.

Parameters:
- MEM_TIMEOUT, 16: cycles to wait for mem_ready before raising mem_err; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], sampled in DECODE
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- reg_write  out  1  register file write
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  3  8:1 mux select: 000 regB, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm; 101–111 unused, never driven
- alu_op  out  2  00 add, 01 sub, 10 funct-decode, 11 or
- pc_src  out  3  8:1 mux select: 000 ALU result, 001 ALUOut, 010 jump target; others unused
- illegal_op  out  1  sticky unsupported-opcode flag
- mem_err  out  1  sticky memory timeout flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset
  - While reset = 1: every output is 0, including sticky flags and state_dbg.
  - On the first clk edge after reset falls, the state is FETCH.
  - Reset asserted mid-operation aborts immediately: the next state is FETCH and no partial writes occur after the reset cycle.
- States and encodings
  - FETCH(0): mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 001, alu_op = 00, pc_src = 000.
    - ir_write and pc_write = mem_ready.
    - Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE(1): alu_src_a = 0, alu_src_b = 011, alu_op = 00 (precomputes the branch target).
    - Next state by opcode:
      - 000000 → EXEC
      - 100011 / 101011 → MEMADR
      - 000100 / 000101 → BRANCH
      - 001000 → ADDIEX
      - 001101 → ORIEX
      - 000010 → JUMP
      - any other opcode → ILLEGAL
  - MEMADR(2): alu_src_a = 1, alu_src_b = 010, alu_op = 00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_req = 1, iord = 1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB(4): reg_write = 1, reg_dst = 00, mem_to_reg = 01. Goes to FETCH.
  - MEMWR(5): mem_req = 1, mem_we = 1, iord = 1. Waits for mem_ready, then goes to FETCH.
  - EXEC(6): alu_src_a = 1, alu_src_b = 000, alu_op = 10. Goes to ALUWB.
  - ALUWB(7): reg_write = 1, reg_dst = 01, mem_to_reg = 00. Goes to FETCH.
  - BRANCH(8): alu_src_a = 1, alu_src_b = 000, alu_op = 01, pc_src = 001.
    - pc_write = zero for beq; pc_write = ~zero for bne.
    - The opcode is latched in DECODE; the bne/beq distinction comes from the latched opcode.
    - Goes to FETCH.
  - ADDIEX(9): alu_src_a = 1, alu_src_b = 010, alu_op = 00. Goes to IWB.
  - ORIEX(10): alu_src_a = 1, alu_src_b = 100, alu_op = 11. Goes to IWB.
  - IWB(11): reg_write = 1, reg_dst = 00, mem_to_reg = 00. Goes to FETCH.
  - JUMP(12): pc_write = 1, pc_src = 010. Goes to FETCH.
  - ILLEGAL(13): sets illegal_op. Goes to FETCH; the instruction has no architectural effect.
- Handshake
  - mem_req is held high continuously in a memory state until the cycle in which mem_ready = 1.
  - mem_ready outside a memory state is ignored.
  - The access completes in the same cycle that mem_ready is sampled high.
- Timeout
  - A wait counter resets on entry to each memory state.
  - If it reaches MEM_TIMEOUT with no mem_ready: set mem_err, abandon the access (no ir_write, pc_write or reg_write) and go to FETCH.
- Latency with mem_ready held high:
  - R-type 4 cycles, lw 5, sw 4, branch 3, addi/ori 4, j 3.
- Unused mux selects: 101–111 on alu_src_b and 011–111 on pc_src never appear on the outputs.

Optional Feature:
- Macro MC_JAL_EN.
- Defined:
  - Opcode 000011 in DECODE goes to JAL(14).
  - JAL drives reg_write = 1, reg_dst = 10, mem_to_reg = 10, pc_write = 1, pc_src = 010, then goes to FETCH.
- Undefined: 000011 goes to ILLEGAL and state 14 does not exist.

Test Plan:
- Reset held 3 cycles mid-MEMRD → all outputs 0 during reset; state_dbg = 0 and mem_req = 1 on the first cycle after release.
- R-type (opcode 000000), mem_ready tied 1 → state sequence 0, 1, 6, 7, 0; ALUWB shows reg_write = 1, reg_dst = 01; EXEC shows alu_src_b = 000, alu_op = 10.
- lw with mem_ready delayed 3 cycles in MEMRD → mem_req stays 1 for 4 cycles; MEMWB follows with mem_to_reg = 01; total latency 8 cycles.
- beq with zero = 0, then bne with zero = 0 → BRANCH pc_write = 0 for beq, 1 for bne; pc_src = 001 in both.
- ori (001101) → ORIEX alu_src_b = 100, alu_op = 11; opcode 111111 → illegal_op = 1 and held until reset, with no reg_write.
- mem_ready never asserted in FETCH with MEM_TIMEOUT = 16 → mem_err = 1 after 16 cycles, ir_write never 1, state returns to FETCH; with MC_JAL_EN, opcode 000011 → state 14 with reg_dst = 10, mem_to_reg = 10, pc_src = 010.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Memory request/ready handshake between the multicycle control unit (master)
// and the memory system (slave).
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the MIPS multicycle datapath with a timed memory handshake.
// Optional macro MC_JAL_EN adds the JAL instruction (state 14).
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mc_control_fsm_if.master        mem,
  input  logic [5:0]              opcode,
  input  logic                    zero,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic                    alu_src_a,
  output logic [2:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [2:0]              pc_src,
  output logic                    illegal_op,
  output logic                    mem_err,
  output logic [3:0]              state_dbg
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    IWB     = 4'd11,
    JUMP    = 4'd12,
`ifdef MC_JAL_EN
    ILLEGAL = 4'd13,
    JAL     = 4'd14
`else
    ILLEGAL = 4'd13
`endif
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [5:0]         op_lat;
  logic [CNT_W-1:0]   wait_cnt;
  logic               illegal_q;
  logic               mem_err_q;
  logic               in_mem;
  logic               timeout;
  logic               mem_req_c;
  logic               mem_we_c;
  logic               iord_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_next;
      // The wait counter restarts whenever a memory state is (re)entered.
      if (timeout || (state_next != state))
        wait_cnt <= '0;
      else if (in_mem)
        wait_cnt <= wait_cnt + 1'b1;
      if (state_next == ILLEGAL)
        illegal_q <= 1'b1;
      if (timeout)
        mem_err_q <= 1'b1;
    end
  end

  // Branch polarity and lw/sw choice come from the opcode seen in DECODE.
  always_ff @(posedge clk) begin
    if (state == DECODE)
      op_lat <= opcode;
  end

  assign in_mem = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 3'b000;
    alu_op     = 2'b00;
    pc_src     = 3'b000;
    if (!reset) begin
      timeout = in_mem && !mem.mem_ready && (MEM_TIMEOUT != 0) &&
                (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
      case (state)
        FETCH: begin
          mem_req_c = 1'b1;
          alu_src_b = 3'b001;
          ir_write  = mem.mem_ready;
          pc_write  = mem.mem_ready;
          if (mem.mem_ready)
            state_next = DECODE;
        end
        DECODE: begin
          alu_src_b = 3'b011;
          case (opcode)
            OP_RTYPE:       state_next = EXEC;
            OP_LW, OP_SW:   state_next = MEMADR;
            OP_BEQ, OP_BNE: state_next = BRANCH;
            OP_ADDI:        state_next = ADDIEX;
            OP_ORI:         state_next = ORIEX;
            OP_J:           state_next = JUMP;
`ifdef MC_JAL_EN
            OP_JAL:         state_next = JAL;
`endif
            default:        state_next = ILLEGAL;
          endcase
        end
        MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 3'b010;
          state_next = (op_lat == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
          if (mem.mem_ready)
            state_next = MEMWB;
          else if (timeout)
            state_next = FETCH;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          state_next = FETCH;
        end
        MEMWR: begin
          mem_req_c = 1'b1;
          mem_we_c  = 1'b1;
          iord_c    = 1'b1;
          if (mem.mem_ready || timeout)
            state_next = FETCH;
        end
        EXEC: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b10;
          state_next = ALUWB;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b01;
          state_next = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 3'b001;
          pc_write   = (op_lat == OP_BNE) ? ~zero : zero;
          state_next = FETCH;
        end
        ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 3'b010;
          state_next = IWB;
        end
        ORIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 3'b100;
          alu_op     = 2'b11;
          state_next = IWB;
        end
        IWB: begin
          reg_write  = 1'b1;
          state_next = FETCH;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 3'b010;
          state_next = FETCH;
        end
`ifdef MC_JAL_EN
        JAL: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          pc_write   = 1'b1;
          pc_src     = 3'b010;
          state_next = FETCH;
        end
`endif
        default: state_next = FETCH;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_we   = mem_we_c;
  assign mem.iord     = iord_c;
  assign illegal_op   = illegal_q & ~reset;
  assign mem_err      = mem_err_q & ~reset;
  assign state_dbg    = reset ? 4'd0 : state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: stimulus pushes per-cycle expectations into a
// scoreboard queue; a negedge monitor pops and compares them against the DUT.
module tb_mc_control_fsm;

  localparam int S_STATE = 0, S_MEMREQ = 1, S_MEMWE = 2, S_IORD = 3, S_IRW = 4,
                 S_PCW = 5, S_REGW = 6, S_REGDST = 7, S_M2R = 8, S_SRCA = 9,
                 S_SRCB = 10, S_ALUOP = 11, S_PCSRC = 12, S_ILL = 13, S_MERR = 14;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111,
                         JALOP = 6'b000011;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        ir_write, pc_write, reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0]  reg_dst, mem_to_reg, alu_op;
  logic [2:0]  alu_src_b, pc_src;
  logic [3:0]  state_dbg;

  mc_control_fsm_if mif ();

  mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mif),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .state_dbg  (state_dbg)
  );

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get(input int sig);
    case (sig)
      S_STATE:  return int'(state_dbg);
      S_MEMREQ: return int'(mif.mem_req);
      S_MEMWE:  return int'(mif.mem_we);
      S_IORD:   return int'(mif.iord);
      S_IRW:    return int'(ir_write);
      S_PCW:    return int'(pc_write);
      S_REGW:   return int'(reg_write);
      S_REGDST: return int'(reg_dst);
      S_M2R:    return int'(mem_to_reg);
      S_SRCA:   return int'(alu_src_a);
      S_SRCB:   return int'(alu_src_b);
      S_ALUOP:  return int'(alu_op);
      S_PCSRC:  return int'(pc_src);
      S_ILL:    return int'(illegal_op);
      S_MERR:   return int'(mem_err);
      default:  return -1;
    endcase
  endfunction

  // Monitor: compares every expectation stamped with the current cycle.
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        tests++;
        if (e.cyc != cyc) begin
          fails++;
          $display("FAIL %s cyc=%0d expectation never sampled (now cyc=%0d)", e.name, e.cyc, cyc);
        end else begin
          got = get(e.sig);
          if (got != e.val) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", e.name, cyc, got, e.val);
          end
        end
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    reset         = r;
    opcode        = op;
    zero          = z;
    mif.mem_ready = rdy;
  endtask

  task automatic ex(input string n, input int sig, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = n;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; opcode = RT; zero = 1'b0; mif.mem_ready = 1'b1;

    // Reset cycle with mem_ready high: everything must be quiet.
    step(1, RT, 0, 1);
    ex("rst_state", S_STATE, 0); ex("rst_memreq", S_MEMREQ, 0);
    ex("rst_irw", S_IRW, 0);     ex("rst_pcw", S_PCW, 0);
    ex("rst_srcb", S_SRCB, 0);   ex("rst_ill", S_ILL, 0);

    // R-type
    step(0, RT, 0, 1);
    ex("r_fetch_st", S_STATE, 0); ex("r_fetch_req", S_MEMREQ, 1);
    ex("r_fetch_irw", S_IRW, 1);  ex("r_fetch_pcw", S_PCW, 1);
    ex("r_fetch_srcb", S_SRCB, 1); ex("r_fetch_iord", S_IORD, 0);
    step(0, RT, 0, 1);
    ex("r_dec_st", S_STATE, 1); ex("r_dec_srcb", S_SRCB, 3);
    ex("r_dec_req", S_MEMREQ, 0); ex("r_dec_irw", S_IRW, 0);
    step(0, RT, 0, 1);
    ex("r_exec_st", S_STATE, 6); ex("r_exec_srcb", S_SRCB, 0);
    ex("r_exec_aluop", S_ALUOP, 2); ex("r_exec_srca", S_SRCA, 1);
    step(0, RT, 0, 1);
    ex("r_wb_st", S_STATE, 7); ex("r_wb_regw", S_REGW, 1);
    ex("r_wb_regdst", S_REGDST, 1); ex("r_wb_m2r", S_M2R, 0);

    // lw with mem_ready delayed 3 cycles in MEMRD
    step(0, LW, 0, 1); ex("lw_fetch_st", S_STATE, 0);
    step(0, LW, 0, 1); ex("lw_dec_st", S_STATE, 1);
    step(0, LW, 0, 0);
    ex("lw_adr_st", S_STATE, 2); ex("lw_adr_srcb", S_SRCB, 2); ex("lw_adr_srca", S_SRCA, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, LW, 0, (i == 3));
      ex("lw_rd_st", S_STATE, 3); ex("lw_rd_req", S_MEMREQ, 1);
      ex("lw_rd_iord", S_IORD, 1); ex("lw_rd_regw", S_REGW, 0);
    end
    step(0, LW, 0, 0);
    ex("lw_wb_st", S_STATE, 4); ex("lw_wb_regw", S_REGW, 1);
    ex("lw_wb_m2r", S_M2R, 1); ex("lw_wb_regdst", S_REGDST, 0);

    // sw
    step(0, SW, 0, 1); ex("sw_fetch_st", S_STATE, 0);
    step(0, SW, 0, 1); ex("sw_dec_st", S_STATE, 1);
    step(0, SW, 0, 1); ex("sw_adr_st", S_STATE, 2);
    step(0, SW, 0, 1);
    ex("sw_wr_st", S_STATE, 5); ex("sw_wr_we", S_MEMWE, 1);
    ex("sw_wr_req", S_MEMREQ, 1); ex("sw_wr_iord", S_IORD, 1);

    // beq with zero=0: not taken
    step(0, BEQ, 0, 1); ex("beq_fetch_st", S_STATE, 0);
    step(0, BEQ, 0, 1); ex("beq_dec_st", S_STATE, 1);
    step(0, BEQ, 0, 1);
    ex("beq_br_st", S_STATE, 8); ex("beq_br_pcw", S_PCW, 0);
    ex("beq_br_pcsrc", S_PCSRC, 1); ex("beq_br_aluop", S_ALUOP, 1);

    // bne with zero=0: taken, using the opcode latched in DECODE
    step(0, BNE, 0, 1); ex("bne_fetch_st", S_STATE, 0);
    step(0, BNE, 0, 1); ex("bne_dec_st", S_STATE, 1);
    step(0, BEQ, 0, 1);
    ex("bne_br_st", S_STATE, 8); ex("bne_br_pcw", S_PCW, 1); ex("bne_br_pcsrc", S_PCSRC, 1);

    // beq with zero=1: taken
    step(0, BEQ, 1, 1); ex("beqz_fetch_st", S_STATE, 0);
    step(0, BEQ, 1, 1); ex("beqz_dec_st", S_STATE, 1);
    step(0, BEQ, 1, 1); ex("beqz_br_pcw", S_PCW, 1);

    // addi
    step(0, ADDI, 0, 1); ex("addi_fetch_st", S_STATE, 0);
    step(0, ADDI, 0, 1); ex("addi_dec_st", S_STATE, 1);
    step(0, ADDI, 0, 1);
    ex("addi_ex_st", S_STATE, 9); ex("addi_ex_srcb", S_SRCB, 2); ex("addi_ex_aluop", S_ALUOP, 0);
    step(0, ADDI, 0, 1);
    ex("addi_wb_st", S_STATE, 11); ex("addi_wb_regw", S_REGW, 1); ex("addi_wb_regdst", S_REGDST, 0);

    // ori
    step(0, ORI, 0, 1); ex("ori_fetch_st", S_STATE, 0);
    step(0, ORI, 0, 1); ex("ori_dec_st", S_STATE, 1);
    step(0, ORI, 0, 1);
    ex("ori_ex_st", S_STATE, 10); ex("ori_ex_srcb", S_SRCB, 4); ex("ori_ex_aluop", S_ALUOP, 3);
    step(0, ORI, 0, 1);
    ex("ori_wb_st", S_STATE, 11); ex("ori_wb_regw", S_REGW, 1); ex("ori_wb_m2r", S_M2R, 0);

    // j
    step(0, JMP, 0, 1); ex("j_fetch_st", S_STATE, 0);
    step(0, JMP, 0, 1); ex("j_dec_st", S_STATE, 1);
    step(0, JMP, 0, 1);
    ex("j_st", S_STATE, 12); ex("j_pcw", S_PCW, 1); ex("j_pcsrc", S_PCSRC, 2);

    // Unsupported opcode 111111
    step(0, BAD, 0, 1); ex("bad_fetch_st", S_STATE, 0); ex("bad_fetch_ill", S_ILL, 0);
    step(0, BAD, 0, 1); ex("bad_dec_st", S_STATE, 1); ex("bad_dec_ill", S_ILL, 0);
    step(0, BAD, 0, 1);
    ex("bad_st", S_STATE, 13); ex("bad_ill", S_ILL, 1);
    ex("bad_regw", S_REGW, 0); ex("bad_pcw", S_PCW, 0);

    // Opcode 000011: JAL when enabled, otherwise illegal
    step(0, JALOP, 0, 1); ex("jal_fetch_st", S_STATE, 0); ex("jal_fetch_ill", S_ILL, 1);
    step(0, JALOP, 0, 1); ex("jal_dec_st", S_STATE, 1);
    step(0, JALOP, 0, 1);
`ifdef MC_JAL_EN
    ex("jal_st", S_STATE, 14); ex("jal_regw", S_REGW, 1); ex("jal_regdst", S_REGDST, 2);
    ex("jal_m2r", S_M2R, 2); ex("jal_pcsrc", S_PCSRC, 2); ex("jal_pcw", S_PCW, 1);
`else
    ex("jal_off_st", S_STATE, 13); ex("jal_off_regw", S_REGW, 0);
`endif

    // FETCH timeout: 16 cycles without mem_ready
    for (int i = 0; i < 16; i++) begin
      step(0, RT, 0, 0);
      ex("to_st", S_STATE, 0); ex("to_req", S_MEMREQ, 1);
      ex("to_irw", S_IRW, 0); ex("to_merr", S_MERR, 0);
    end
    step(0, RT, 0, 1);
    ex("to_after_st", S_STATE, 0); ex("to_after_merr", S_MERR, 1); ex("to_after_irw", S_IRW, 1);
    step(0, RT, 0, 1); ex("to_dec_st", S_STATE, 1); ex("to_dec_merr", S_MERR, 1);
    step(0, RT, 0, 1); ex("to_exec_st", S_STATE, 6);
    step(0, RT, 0, 1); ex("to_wb_st", S_STATE, 7);

    // Reset held 3 cycles in the middle of MEMRD
    step(0, LW, 0, 1); ex("mr_fetch_st", S_STATE, 0);
    step(0, LW, 0, 1); ex("mr_dec_st", S_STATE, 1);
    step(0, LW, 0, 0); ex("mr_adr_st", S_STATE, 2);
    step(0, LW, 0, 0); ex("mr_rd_st", S_STATE, 3); ex("mr_rd_req", S_MEMREQ, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, LW, 0, 1);
      ex("mr_rst_st", S_STATE, 0); ex("mr_rst_req", S_MEMREQ, 0);
      ex("mr_rst_iord", S_IORD, 0); ex("mr_rst_regw", S_REGW, 0);
      ex("mr_rst_irw", S_IRW, 0); ex("mr_rst_merr", S_MERR, 0);
      ex("mr_rst_ill", S_ILL, 0);
    end
    step(0, LW, 0, 0);
    ex("mr_rel_st", S_STATE, 0); ex("mr_rel_req", S_MEMREQ, 1);
    ex("mr_rel_iord", S_IORD, 0); ex("mr_rel_merr", S_MERR, 0); ex("mr_rel_ill", S_ILL, 0);
    step(0, LW, 0, 1); ex("mr_fetch2_st", S_STATE, 0); ex("mr_fetch2_irw", S_IRW, 1);
    step(0, LW, 0, 0); ex("mr_dec2_st", S_STATE, 1);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
